// File: rtl/imm_packer_pkg.sv
// imm_packer_pkg: constants shared by the program-load packer and the
// decode-side immediate generator.
//   IMM_*    immediate-format select encoding (same on both sides)
//   ST_*     packer session state encoding
package imm_packer_pkg;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_LOAD = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/imm_packer_encoder.sv
// imm_encoder: combinational inverse of the immediate generator.
// Scatters imm_value into the field positions of the selected format and
// keeps every other bit of base_instr.
//   base_instr  in  32  instruction with non-immediate fields set
//   imm_src     in  2   format select (IMM_I/S/B/J)
//   imm_value   in  32  signed byte immediate
//   instr       out 32  packed instruction
//   ok          out 1   immediate is representable in the selected format
module imm_encoder
   import imm_packer_pkg::*;
(
   input  logic [31:0] base_instr,
   input  logic [1:0]  imm_src,
   input  logic [31:0] imm_value,
   output logic [31:0] instr,
   output logic        ok
);

   // Sign-extension checks: the upper bits must all replicate the top
   // encodable bit.
   logic fits_12;
   logic fits_13;
   logic fits_21;

   assign fits_12 = (&imm_value[31:11]) | ~(|imm_value[31:11]);
   assign fits_13 = (&imm_value[31:12]) | ~(|imm_value[31:12]);
   assign fits_21 = (&imm_value[31:20]) | ~(|imm_value[31:20]);

   always_comb begin
      instr = base_instr;
      ok    = 1'b0;
      case (imm_src)
         IMM_I: begin
            instr[31:20] = imm_value[11:0];
            ok           = fits_12;
         end
         IMM_S: begin
            instr[31:25] = imm_value[11:5];
            instr[11:7]  = imm_value[4:0];
            ok           = fits_12;
         end
         IMM_B: begin
            instr[31]    = imm_value[12];
            instr[7]     = imm_value[11];
            instr[30:25] = imm_value[10:5];
            instr[11:8]  = imm_value[4:1];
            ok           = fits_13 & ~imm_value[0];
         end
         default: begin
            instr[31]    = imm_value[20];
            instr[19:12] = imm_value[19:12];
            instr[20]    = imm_value[11];
            instr[30:21] = imm_value[10:1];
            ok           = fits_21 & ~imm_value[0];
         end
      endcase
   end

endmodule

// File: rtl/imm_packer.sv
// imm_packer: packs immediates into base instructions and streams the
// results into instruction memory at consecutive word addresses.
//   clk, rst_n                clock, async active-low reset
//   start, finish             open/restart and close a load session
//   in_valid, in_ready        input handshake
//   imm_src, imm_value        immediate format and value
//   base_instr                instruction with non-immediate fields set
//   imem_we/addr/wdata        registered instruction-memory write port
//   busy, done                session open / session closed (sticky)
//   range_err, err_index      sticky reject flag, index of first reject
//   word_count                words written this session
//
// state   | meaning
// IDLE    | out of reset, no session yet
// LOAD    | session open, accepting words
// DONE    | session closed by finish or DEPTH writes, waiting for start
module imm_packer
   import imm_packer_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                DEPTH     = 64,
   localparam int               CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        imm_src,
   input  logic [31:0]       imm_value,
   input  logic [31:0]       base_instr,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              range_err,
   output logic [CNT_W-1:0]  err_index,
   output logic [CNT_W-1:0]  word_count
);

   localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEPTH - 1);

   logic [1:0]        state;
   logic [ADDR_W-1:0] ptr;
   logic [CNT_W-1:0]  in_idx;
   logic [31:0]       enc_word;
   logic              enc_ok;
   logic              accept;

   imm_encoder u_imm_encoder (
      .base_instr (base_instr),
      .imm_src    (imm_src),
      .imm_value  (imm_value),
      .instr      (enc_word),
      .ok         (enc_ok)
   );

   assign busy     = (state == ST_LOAD);
   assign in_ready = busy && (word_count < CNT_DEPTH) && !finish;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         ptr        <= BASE_ADDR;
         word_count <= '0;
         in_idx     <= '0;
         range_err  <= 1'b0;
         err_index  <= '0;
         done       <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= BASE_ADDR;
         imem_wdata <= '0;
      end else begin
         imem_we <= 1'b0;
         // start overrides everything, including an accept this cycle;
         // a write registered on the previous edge is already on the port.
         if (start) begin
            state      <= ST_LOAD;
            ptr        <= BASE_ADDR;
            word_count <= '0;
            in_idx     <= '0;
            range_err  <= 1'b0;
            err_index  <= '0;
            done       <= 1'b0;
         end else if (state == ST_LOAD) begin
            if (accept) begin
               in_idx <= in_idx + CNT_W'(1);
               if (enc_ok) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= ptr;
                  imem_wdata <= enc_word;
                  ptr        <= ptr + ADDR_W'(4);
                  word_count <= word_count + CNT_W'(1);
                  if (word_count == CNT_LAST) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end
               end else begin
                  range_err <= 1'b1;
                  if (!range_err) begin
                     err_index <= in_idx;
                  end
               end
            end
            // finish masks in_ready, so it never coincides with an accept
            if (finish) begin
               state <= ST_DONE;
               done  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_imm_packer.sv
module tb_imm_packer;
   import imm_packer_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              finish = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [1:0]        imm_src = 2'b00;
   logic [31:0]       imm_value = '0;
   logic [31:0]       base_instr = '0;
   logic              imem_we;
   logic [31:0]       imem_addr;
   logic [31:0]       imem_wdata;
   logic              busy;
   logic              done;
   logic              range_err;
   logic [CNT_W-1:0]  err_index;
   logic [CNT_W-1:0]  word_count;

   logic [1:0]  e_src = 2'b00;
   logic [31:0] e_imm = '0;
   logic [31:0] e_base = '0;
   logic [31:0] e_word;
   logic        e_ok;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   imm_packer #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .finish     (finish),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .imm_src    (imm_src),
      .imm_value  (imm_value),
      .base_instr (base_instr),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .busy       (busy),
      .done       (done),
      .range_err  (range_err),
      .err_index  (err_index),
      .word_count (word_count)
   );

   imm_encoder u_enc (
      .base_instr (e_base),
      .imm_src    (e_src),
      .imm_value  (e_imm),
      .instr      (e_word),
      .ok         (e_ok)
   );

   // Decode-side immediate generator, used as the round-trip reference.
   function automatic logic [31:0] dec_imm(input logic [31:0] i, input logic [1:0] src);
      case (src)
         IMM_I:   dec_imm = {{20{i[31]}}, i[31:20]};
         IMM_S:   dec_imm = {{20{i[31]}}, i[31:25], i[11:7]};
         IMM_B:   dec_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         default: dec_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      endcase
   endfunction

   function automatic logic [31:0] imm_mask(input logic [1:0] src);
      case (src)
         IMM_I:   imm_mask = 32'hFFF0_0000;
         IMM_S:   imm_mask = 32'hFE00_0F80;
         IMM_B:   imm_mask = 32'hFE00_0F80;
         default: imm_mask = 32'hFFFF_F000;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base);
      in_valid   = 1'b1;
      imm_src    = src;
      imm_value  = imm;
      base_instr = base;
   endtask

   task automatic chk_wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input int wc);
      chk({tag, ".we"}, 32'(imem_we), 32'd1);
      chk({tag, ".addr"}, imem_addr, addr);
      chk({tag, ".wdata"}, imem_wdata, data);
      chk({tag, ".wc"}, 32'(word_count), 32'(wc));
   endtask

   typedef struct {
      logic [1:0]  src;
      logic [31:0] imm;
      logic [31:0] base;
      logic        ok;
   } enc_vec_t;

   enc_vec_t enc_tab[10] = '{
      '{IMM_I, 32'h0000_07FF, 32'hFFFF_FFFF, 1'b1},
      '{IMM_I, 32'hFFFF_F800, 32'h0000_0013, 1'b1},
      '{IMM_S, 32'hFFFF_FABC, 32'h0123_4567, 1'b1},
      '{IMM_S, 32'h0000_0800, 32'h0000_0023, 1'b0},
      '{IMM_B, 32'h0000_0FFE, 32'hA5A5_A5A5, 1'b1},
      '{IMM_B, 32'hFFFF_F000, 32'h0000_0063, 1'b1},
      '{IMM_B, 32'h0000_1000, 32'h0000_0063, 1'b0},
      '{IMM_J, 32'h000F_FFFE, 32'h5A5A_5A5A, 1'b1},
      '{IMM_J, 32'hFFF0_0000, 32'h0000_006F, 1'b1},
      '{IMM_J, 32'h0000_0003, 32'h0000_006F, 1'b0}
   };

   initial begin
      // Reset state
      #12;
      chk("rst.we", 32'(imem_we), 32'd0);
      chk("rst.addr", imem_addr, 32'h0);
      chk("rst.wdata", imem_wdata, 32'h0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.rerr", 32'(range_err), 32'd0);
      chk("rst.eidx", 32'(err_index), 32'd0);
      chk("rst.wc", 32'(word_count), 32'd0);
      chk("rst.rdy", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Encoder round-trip through the decode-side generator
      for (int k = 0; k < 10; k++) begin
         e_src  = enc_tab[k].src;
         e_imm  = enc_tab[k].imm;
         e_base = enc_tab[k].base;
         #1;
         chk($sformatf("enc%0d.ok", k), 32'(e_ok), 32'(enc_tab[k].ok));
         if (enc_tab[k].ok) begin
            chk($sformatf("enc%0d.rt", k), dec_imm(e_word, e_src), enc_tab[k].imm);
            chk($sformatf("enc%0d.keep", k), e_word & ~imm_mask(e_src),
                enc_tab[k].base & ~imm_mask(e_src));
         end
      end

      // Session 1: I, then S and B back-to-back
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("s1.busy", 32'(busy), 32'd1);
      chk("s1.rdy", 32'(in_ready), 32'd1);
      drive(IMM_I, 32'hFFFF_FFFF, 32'h0000_0093);
      tick();
      chk_wr("i0", 32'h0, 32'hFFF0_0093, 1);
      drive(IMM_S, 32'd8, 32'h0020_A023);
      tick();
      chk_wr("s0", 32'h4, 32'h0020_A423, 2);
      drive(IMM_B, 32'hFFFF_FFFC, 32'h0000_0063);
      tick();
      chk_wr("b0", 32'h8, 32'hFE00_0EE3, 3);
      chk("b0.rt", dec_imm(imem_wdata, IMM_B), 32'hFFFF_FFFC);

      // start with a simultaneous accept: restart wins, accept discarded
      drive(IMM_I, 32'd1, 32'h0000_0013);
      start = 1'b1;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      chk("rs.we", 32'(imem_we), 32'd0);
      chk("rs.wc", 32'(word_count), 32'd0);
      chk("rs.busy", 32'(busy), 32'd1);

      // Session 2: J, rejected I, B, rejected B, then fill to DEPTH
      drive(IMM_J, 32'h0000_0800, 32'h0000_00EF);
      tick();
      chk_wr("j0", 32'h0, 32'h0010_00EF, 1);
      drive(IMM_I, 32'd2048, 32'h0000_0013);
      tick();
      chk("ibad.we", 32'(imem_we), 32'd0);
      chk("ibad.rerr", 32'(range_err), 32'd1);
      chk("ibad.eidx", 32'(err_index), 32'd1);
      chk("ibad.wc", 32'(word_count), 32'd1);
      drive(IMM_B, 32'd6, 32'h0000_0063);
      tick();
      chk_wr("b6", 32'h4, 32'h0000_0363, 2);
      drive(IMM_B, 32'd5, 32'h0000_0063);
      tick();
      chk("b5.we", 32'(imem_we), 32'd0);
      chk("b5.eidx", 32'(err_index), 32'd1);
      chk("b5.wc", 32'(word_count), 32'd2);
      drive(IMM_I, 32'd5, 32'h0000_0013);
      tick();
      chk_wr("i5", 32'h8, 32'h0050_0013, 3);
      chk("i5.done", 32'(done), 32'd0);
      drive(IMM_I, 32'hFFFF_F800, 32'h0000_0013);
      tick();
      chk_wr("imin", 32'hC, 32'h8000_0013, 4);
      chk("full.done", 32'(done), 32'd1);
      chk("full.busy", 32'(busy), 32'd0);
      chk("full.rdy", 32'(in_ready), 32'd0);
      drive(IMM_I, 32'd1, 32'h0000_0013);
      tick();
      in_valid = 1'b0;
      chk("over.we", 32'(imem_we), 32'd0);
      chk("over.wc", 32'(word_count), 32'd4);
      chk("over.rerr", 32'(range_err), 32'd1);

      // Session 3: restart from DONE, pending write survives finish
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("s3.done", 32'(done), 32'd0);
      chk("s3.rerr", 32'(range_err), 32'd0);
      chk("s3.eidx", 32'(err_index), 32'd0);
      chk("s3.wc", 32'(word_count), 32'd0);
      drive(IMM_S, 32'hFFFF_FFF0, 32'h0000_0023);
      tick();
      chk_wr("s3w", 32'h0, 32'hFE00_0823, 1);
      finish = 1'b1;
      #1;
      chk("fin.rdy", 32'(in_ready), 32'd0);
      tick();
      finish   = 1'b0;
      in_valid = 1'b0;
      chk("fin.we", 32'(imem_we), 32'd0);
      chk("fin.done", 32'(done), 32'd1);
      chk("fin.wc", 32'(word_count), 32'd1);

      // Session 4: reset during the write cycle
      start = 1'b1;
      tick();
      start = 1'b0;
      drive(IMM_I, 32'd3, 32'h0000_0013);
      tick();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("mrst.we", 32'(imem_we), 32'd0);
      chk("mrst.addr", imem_addr, 32'h0);
      chk("mrst.wdata", imem_wdata, 32'h0);
      chk("mrst.busy", 32'(busy), 32'd0);
      chk("mrst.wc", 32'(word_count), 32'd0);
      chk("mrst.done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post.busy", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/imm_packer.md
Name: imm_packer

Overview:
- Inverse of the decode-side immediate generator. Takes a base instruction word, an immediate value and an immediate-format select.
- Inserts the immediate bits into the I/S/B/J field positions and range-checks the value.
- Streams the assembled words into instruction memory at consecutive word addresses.
- Sits in the program-load path in front of the instruction memory of the single-cycle core.

Parameters:
- ADDR_W, 32, width of imem_addr.
- BASE_ADDR, 0, byte address of the first word written after start.
- DEPTH, 64, maximum words per load session; CNT_W = $clog2(DEPTH+1), derived.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; opens or restarts a load session.
- finish  in  1  pulse; ends the session early.
- in_valid  in  1  input word present.
- in_ready  out  1  packer accepts input this cycle.
- imm_src  in  2  00=I, 01=S, 10=B, 11=J (same encoding as the decode side).
- imm_value  in  32  signed byte immediate.
- base_instr  in  32  instruction with opcode/rd/rs/funct set; immediate bit positions are ignored.
- imem_we  out  1  write strobe, one cycle per word.
- imem_addr  out  ADDR_W  byte address of the write.
- imem_wdata  out  32  assembled instruction.
- busy  out  1  session open.
- done  out  1  session closed, sticky until start.
- range_err  out  1  sticky: at least one word was rejected.
- err_index  out  CNT_W  input index of the first rejected word.
- word_count  out  CNT_W  words written this session.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0; imem_addr=BASE_ADDR.
- FSM states: IDLE, LOAD, DONE.
  - IDLE --start--> LOAD.
  - LOAD --finish, or word_count reaches DEPTH--> DONE.
  - DONE --start--> LOAD.
- On entering LOAD:
  - write pointer = BASE_ADDR.
  - word_count, range_err, err_index and the input index are cleared.
  - done=0.
- busy=1 only in LOAD. in_ready = (state==LOAD) && (word_count < DEPTH) && !finish.
- Accept = in_valid && in_ready. Throughput is one word per cycle; back-to-back accepts are legal.
- Latency is 1 cycle: an accept in cycle N gives imem_we=1 in cycle N+1, with registered imem_addr/imem_wdata. imem_we=0 in all other cycles.
- Packing: non-immediate bits are copied from base_instr.
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1].
- Range check:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
- Rejected word:
  - No write; pointer and word_count are unchanged.
  - range_err is set. err_index is captured only on the first error of the session.
  - The input index still increments.
- Accepted good word: the pointer advances by 4 and word_count increments, both in the write cycle.
- The DEPTH-th good write moves the FSM to DONE in the same edge; in_ready drops.
- Simultaneous events:
  - start in LOAD restarts the session. start has priority over an accept in the same cycle; that accept is discarded.
  - start together with finish: start wins.
  - A pending write from cycle N-1 always completes, even if finish or start arrives in cycle N.
- Reset mid-session aborts immediately; a pending write is lost.

Decomposition:
- Shared package (alongside the decoder's constants):
  - IMM_I=2'b00, IMM_S=2'b01, IMM_B=2'b10, IMM_J=2'b11.
  - State encoding IDLE/LOAD/DONE.
- One natural combinational sub-module: imm_encoder. Inputs are base_instr, imm_src and imm_value; outputs are the packed word and an ok flag.
- imm_encoder is checked in the bench by round-tripping through the decode-side generator for all four formats.

Test Plan:
- start, then I-type: base 0x00000093, imm 0xFFFFFFFF -> next cycle imem_we=1, addr 0x0, wdata 0xFFF00093, word_count=1.
- S then B back-to-back:
  - S: base 0x0020A023, imm 8 -> wdata 0x0020A423 @0x4.
  - B: base 0x00000063, imm 0xFFFFFFFC -> wdata 0xFE000EE3 @0x8.
- J: base 0x000000EF, imm 0x800 -> wdata 0x001000EF. Then I imm 2048 at input index 1 -> no write, range_err=1, err_index=1. Next good word is written at addr 0x4.
- B with imm 6 (odd bit 0 clear; valid) -> written. B with imm 5 -> rejected.
- DEPTH=4: four good words -> done=1 and busy=0 after the 4th write; in_ready=0; a 5th in_valid produces no write.
- rst_n low on the cycle after an accept -> no imem_we, all outputs 0. start in LOAD -> writes restart at BASE_ADDR and word_count=0.
